ram_cmd_master: RTL
===================

Name: ram_cmd_master

Overview:
Initiator side of the RAM command bus. It converts single read/write requests into the 10-bit opcode+payload sequence on din/rx_valid (W_ADD→W_DATA for writes, R_ADD→R_DATA for reads). It waits for tx_valid/dout from the RAM and returns read data on a response port. It sits between the system request source and the RAM slave.

Parameters:
- ADDR_SIZE, 8: address width and data width; din width is ADDR_SIZE+2.
- TIMEOUT, 15: maximum cycles spent in RWAIT without tx_valid before an error response; legal range ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_SIZE  target address.
- req_wdata  in  ADDR_SIZE  write data; ignored for reads.
- din  out  ADDR_SIZE+2  command to RAM: [9:8] opcode, [7:0] payload.
- rx_valid  out  1  payload qualifier to RAM.
- tx_valid  in  1  RAM read data valid.
- dout  in  ADDR_SIZE  RAM read data.
- rsp_valid  out  1  one-cycle pulse per completed read; no backpressure.
- rsp_rdata  out  ADDR_SIZE  read data; 0 on error.
- rsp_err  out  1  read timed out; valid with rsp_valid.

Behaviour:
- Opcodes: W_ADD=0, W_DATA=1, R_ADD=2, R_DATA=3.
- Reset: state=IDLE, din=0, rx_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout count=0. req_ready is combinational (state==IDLE), so it is 1 in reset.
- din, rx_valid and rsp_* are registered.
- Idle bus value: din={W_ADD,0}, rx_valid=0. Opcode 3 is never driven outside RDATA/RWAIT, so the RAM never raises tx_valid spuriously.
- IDLE: on req_valid&&req_ready at edge A:
  - write → WADDR, din<={W_ADD,addr}, rx_valid<=1
  - read → RADDR, din<={R_ADD,addr}, rx_valid<=1
  - The request is captured into internal registers at this edge; req_* inputs are don't-care afterwards.
- WADDR → WDATA at A+1: din<={W_DATA,wdata}, rx_valid<=1.
- WDATA → IDLE at A+2: idle bus value. The RAM writes at A+2. Next request can be accepted at A+3. Writes produce no response.
- RADDR → RDATA at A+1: din<={R_DATA,0}, rx_valid<=1.
- RDATA → RWAIT at A+2: din holds R_DATA, rx_valid<=0, cnt<=0.
- RWAIT, evaluated at each edge A+2+k, k≥1:
  - tx_valid=1: rsp_valid<=1, rsp_rdata<=dout, rsp_err<=0 → IDLE with idle bus value.
  - tx_valid=0 and cnt==TIMEOUT-1: rsp_valid<=1, rsp_rdata<=0, rsp_err<=1 → IDLE.
  - otherwise: cnt++.
- Nominal read: rsp_valid high in the cycle after edge A+3. Timeout response at edge A+2+TIMEOUT.
- rsp_valid is deasserted on the edge after it is set.
- tx_valid is ignored in every state except RWAIT. A stale tx_valid in the cycle after a read completes must not produce a response.
- Back-to-back: the earliest next accept is the edge after returning to IDLE. No overlap of transactions.
- Reset asserted mid-transaction: immediately return to reset values. The transaction is dropped and no response is produced.
- Counter width: $clog2(TIMEOUT+1); saturation is unreachable.

Decomposition:
- Package ram_cmd_pkg:
  - opcode localparams W_ADD/W_DATA/R_ADD/R_DATA (2-bit)
  - state enum IDLE/WADDR/WDATA/RADDR/RDATA/RWAIT
  - default ADDR_SIZE
- No sub-module required. The timeout counter stays inline.

Test Plan:
- Reset: hold rst_n=0 → din=0x000, rx_valid=0, rsp_valid=0, req_ready=1; release → unchanged until a request.
- Write addr 0x05 data 0x3C → din 0x005 then 0x13C with rx_valid=1 for exactly 2 cycles; req_ready low 2 cycles; golden RAM[0x05]=0x3C.
- Read addr 0x05 after the write → din 0x205 then 0x300; rsp_valid pulses at edge A+3 with rsp_rdata=0x3C, rsp_err=0.
- Preload 0x05=0x3C, 0x06=0xA1; read 0x05, then 0x06 accepted at the first ready cycle → responses 0x3C then 0xA1, exactly two rsp_valid pulses, no stale capture.
- tx_valid tied 0, TIMEOUT=15, read 0x10 → rsp_valid at edge A+17 with rsp_err=1, rsp_rdata=0x00; req_ready=1 next cycle.
- Assert rst_n=0 while in RDATA → din=0, rx_valid=0 asynchronously, no rsp_valid; after release a write to 0x07 completes normally.

Source files
------------

// File: rtl/ram_cmd_pkg.sv
// ram_cmd_pkg: shared definitions for the RAM command bus initiator.
//   - 2-bit opcodes carried in the top bits of the RAM command word
//   - FSM state encoding for ram_cmd_master
//   - default address/data width
package ram_cmd_pkg;

    localparam int DEFAULT_ADDR_SIZE = 8;

    localparam logic [1:0] W_ADD  = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] R_ADD  = 2'd2;
    localparam logic [1:0] R_DATA = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WDATA = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RWAIT = 3'd5
    } state_t;

endpackage

// File: rtl/ram_cmd_master_if.sv
// ram_cmd_master_if: request, RAM command and response signals of the
// RAM command bus initiator.
//   Request : req_valid, req_ready, req_write, req_addr, req_wdata
//   RAM bus : din ([ADDR_SIZE+1:ADDR_SIZE] opcode, rest payload), rx_valid,
//             tx_valid, dout
//   Response: rsp_valid, rsp_rdata, rsp_err
// Modports: master = the initiator's view, slave = the environment's view
// (request source, RAM and response sink).
interface ram_cmd_master_if #(
    parameter int ADDR_SIZE = 8
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [ADDR_SIZE-1:0]   req_addr;
    logic [ADDR_SIZE-1:0]   req_wdata;

    logic [ADDR_SIZE+1:0]   din;
    logic                   rx_valid;
    logic                   tx_valid;
    logic [ADDR_SIZE-1:0]   dout;

    logic                   rsp_valid;
    logic [ADDR_SIZE-1:0]   rsp_rdata;
    logic                   rsp_err;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, tx_valid, dout,
        output req_ready, din, rx_valid, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, tx_valid, dout,
        input  req_ready, din, rx_valid, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ram_cmd_master.sv
// ram_cmd_master: turns single read/write requests into the two-word
// opcode+payload sequence of the RAM command bus and returns read data.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - ram_cmd_master_if.master (request, RAM bus, response)
// Writes: W_ADD then W_DATA, no response.
// Reads : R_ADD then R_DATA, then wait up to TIMEOUT cycles for tx_valid;
//         a one-cycle rsp_valid pulse carries the data or an error.
module ram_cmd_master
    import ram_cmd_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_cmd_master_if.master   bus
);

    localparam int                 DW       = ADDR_SIZE + 2;
    localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    // Parked bus word: W_ADD never triggers a RAM response, unlike R_DATA.
    localparam logic [DW-1:0]      IDLE_BUS = {W_ADD, {ADDR_SIZE{1'b0}}};

    state_t                 state_q,     state_d;
    logic [DW-1:0]          din_q,       din_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [ADDR_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q,   rsp_err_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [ADDR_SIZE-1:0]   wdata_q,     wdata_d;

    // State, bus and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            din_q       <= {DW{1'b0}};
            rx_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {ADDR_SIZE{1'b0}};
            rsp_err_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            wdata_q     <= {ADDR_SIZE{1'b0}};
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            rx_valid_q  <= rx_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
        end
    end

    // Next-state and next-output logic of the command sequencer.
    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        rx_valid_d  = rx_valid_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    // Only wdata needs keeping: the address goes out right now.
                    wdata_d    = bus.req_wdata;
                    rx_valid_d = 1'b1;
                    if (bus.req_write) begin
                        state_d = WADDR;
                        din_d   = {W_ADD, bus.req_addr};
                    end else begin
                        state_d = RADDR;
                        din_d   = {R_ADD, bus.req_addr};
                    end
                end else begin
                    din_d      = IDLE_BUS;
                    rx_valid_d = 1'b0;
                end
            end
            WADDR: begin
                state_d    = WDATA;
                din_d      = {W_DATA, wdata_q};
                rx_valid_d = 1'b1;
            end
            WDATA: begin
                state_d    = IDLE;
                din_d      = IDLE_BUS;
                rx_valid_d = 1'b0;
            end
            RADDR: begin
                state_d    = RDATA;
                din_d      = {R_DATA, {ADDR_SIZE{1'b0}}};
                rx_valid_d = 1'b1;
            end
            RDATA: begin
                // din keeps R_DATA while waiting; only the qualifier drops.
                state_d    = RWAIT;
                rx_valid_d = 1'b0;
                cnt_d      = {CNT_W{1'b0}};
            end
            RWAIT: begin
                if (bus.tx_valid) begin
                    state_d     = IDLE;
                    din_d       = IDLE_BUS;
                    rx_valid_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.dout;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    din_d       = IDLE_BUS;
                    rx_valid_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = {ADDR_SIZE{1'b0}};
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = IDLE;
                din_d      = IDLE_BUS;
                rx_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.din       = din_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
